alu_share_arbiter: RTL

//  Shares a single 5-bit Adder (add, or subtract as a + ~b + 1) among NREQ requesters.

---
 rtl/alu_share_pkg.sv | 20 ++
 rtl/alu_share_arbiter_adder.sv | 21 ++
 rtl/alu_share_arbiter_rr_pick.sv | 38 +++
 rtl/alu_share_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_pkg
// Brief   : Shared opcode and FSM state definitions for the shared-adder
//           arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package alu_share_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_adder.sv
`default_nettype none
// ============================================================================
// Module  : Adder
// Brief   : The single shared ripple adder: s = a + b + ci, co = carry out.
// Rev     : 1.0  initial release
// ============================================================================
module Adder #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  // One extra bit of headroom captures the carry out.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker. Scans the request vector
//           starting at i_ptr and returns the first requester found.
// Rev     : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_idx;

  // Walk ptr, ptr+1, ... (mod N); the first set request wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = IW'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Shares one WIDTH-bit adder among NREQ requesters with round-robin
//           arbitration, valid/ready request handshake and a registered
//           per-requester response. One operation in flight at a time.
// Rev     : 1.0  initial release
// ============================================================================
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_co
);

  localparam int IW = $clog2(NREQ);

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_co;
  logic [NREQ-1:0]  r_rsp_valid;

  logic [NREQ-1:0]  w_grant;
  logic [IW-1:0]    w_gidx;
  logic             w_any;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;
  logic             w_rsp_take;
  logic [IW-1:0]    w_ptr_next;
  logic [NREQ-1:0]  w_owner_oh;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Subtraction is a + ~b + 1, so the carry-in doubles as the op bit.
  assign w_b_eff = (r_op == OP_SUB) ? ~r_b : r_b;

  Adder #(.WIDTH(WIDTH)) u_adder (
    .a  (r_a),
    .b  (w_b_eff),
    .ci (r_op),
    .s  (w_sum),
    .co (w_co)
  );

  // Only the owner's rsp_ready matters; other bits are ignored.
  assign w_rsp_take = rsp_ready[r_owner];
  assign w_ptr_next = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_owner_oh = NREQ'(1) << r_owner;

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_data;
  assign rsp_co    = r_co;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and request handshake; req_ready is only offered in IDLE.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_ready = w_grant;
          w_next    = S_EXEC;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: if (w_rsp_take) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, result registration, response valid and rr pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 1'b0;
      r_data      <= '0;
      r_co        <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= req_a[int'(w_gidx)*WIDTH +: WIDTH];
            r_b     <= req_b[int'(w_gidx)*WIDTH +: WIDTH];
            r_op    <= req_op[w_gidx];
            r_owner <= w_gidx;
          end
        end
        S_EXEC: begin
          r_data      <= w_sum;
          r_co        <= w_co;
          r_rsp_valid <= w_owner_oh;
        end
        S_RESP: begin
          if (w_rsp_take) begin
            r_rsp_valid <= '0;
            r_ptr       <= w_ptr_next;
          end
        end
        default: r_rsp_valid <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire
